jk_latch_driver: RTL and testbench

- Initiator side for a bank of WIDTH level-sensitive JK latches, one latch per bit, sharing one enable.
- Accepts a target state word over a valid/ready handshake and reads the bank's present state.
- Derives the per-bit J/K excitation from the present and target states, then pulses the shared enable.
- Reads back the latch outputs after a settle window and reports completion and mismatch. Sits between control logic and the JK latch bank.

---
 rtl/jk_latch_driver_if.sv | 26 ++
 rtl/jk_latch_driver.sv | 174 +++++++++++++++++
 tb/tb_jk_latch_driver.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/jk_latch_driver_if.sv
// Target handshake, JK latch-bank drive/readback and status bundle for jk_latch_driver.
// The driver binds to the slave modport; the requester/bank side binds to master.
interface jk_latch_driver_if #(
  parameter int WIDTH = 4
);
  logic             tgt_valid;
  logic [WIDTH-1:0] tgt_data;
  logic             tgt_ready;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic             e;
  logic [WIDTH-1:0] q_fb;
  logic             busy;
  logic             done;
  logic             mismatch;

  modport master (
    output tgt_valid, tgt_data, q_fb,
    input  tgt_ready, j, k, e, busy, done, mismatch
  );

  modport slave (
    input  tgt_valid, tgt_data, q_fb,
    output tgt_ready, j, k, e, busy, done, mismatch
  );
endinterface

// File: rtl/jk_latch_driver.sv
// JK latch-bank initiator: capture target, drive J/K, pulse e, settle, read back (retry: JK_DRIVER_RETRY_EN).
// Latency: done is high SETTLE_CYCLES+3 edges after the handshake edge (per attempt with retry).
// Backpressure: tgt_ready is low for the whole transaction; tgt_valid is ignored while busy.
module jk_latch_driver #(
  parameter int WIDTH         = 4,
  parameter int SETTLE_CYCLES = 2,
  parameter int MAX_RETRY     = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  jk_latch_driver_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    DRIVE,
    SETTLE,
    CHECK
  } state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic [WIDTH-1:0] cur_q, cur_d;
  logic [WIDTH-1:0] j_q, j_d;
  logic [WIDTH-1:0] k_q, k_d;
  logic             e_q, e_d;
  logic             tgt_ready_q, tgt_ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             mismatch_q, mismatch_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             miss;
  logic             finish;

`ifdef JK_DRIVER_RETRY_EN
  localparam logic [2:0] RETRY_MAX = 3'(MAX_RETRY);
  logic [2:0] retry_q, retry_d;
`endif

  // Outputs are registered one step behind the control state: CAPTURE sets up
  // j/k, DRIVE raises e, CHECK raises done, each visible on the following cycle.
  always_comb begin
    state_d     = state_q;
    tgt_d       = tgt_q;
    cur_d       = cur_q;
    j_d         = j_q;
    k_d         = k_q;
    e_d         = 1'b0;
    tgt_ready_d = tgt_ready_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    mismatch_d  = mismatch_q;
    cnt_d       = cnt_q;
    miss        = (bus.q_fb != tgt_q);
    finish      = 1'b0;
`ifdef JK_DRIVER_RETRY_EN
    retry_d     = retry_q;
`endif

    case (state_q)
      IDLE: begin
        tgt_ready_d = 1'b1;
        busy_d      = 1'b0;
        j_d         = '0;
        k_d         = '0;
        if (bus.tgt_valid && tgt_ready_q) begin
          tgt_d       = bus.tgt_data;
          tgt_ready_d = 1'b0;
          busy_d      = 1'b1;
          state_d     = CAPTURE;
`ifdef JK_DRIVER_RETRY_EN
          retry_d     = '0;
`endif
        end
      end

      CAPTURE: begin
        cur_d   = bus.q_fb;
        j_d     = tgt_q & ~bus.q_fb;
        k_d     = bus.q_fb & ~tgt_q;
        state_d = DRIVE;
      end

      DRIVE: begin
        // Set and reset masks are disjoint, so j=k=1 can never reach the bank.
        e_d     = 1'b1;
        j_d     = tgt_q & ~cur_q;
        k_d     = cur_q & ~tgt_q;
        cnt_d   = SETTLE_LOAD;
        state_d = SETTLE;
      end

      SETTLE: begin
        j_d = '0;
        k_d = '0;
        if (cnt_q == 4'd0) begin
          state_d = CHECK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      CHECK: begin
`ifdef JK_DRIVER_RETRY_EN
        if (miss && (retry_q < RETRY_MAX)) begin
          retry_d = retry_q + 3'd1;
          state_d = CAPTURE;
        end else begin
          finish = 1'b1;
        end
`else
        finish = 1'b1;
`endif
        if (finish) begin
          done_d      = 1'b1;
          mismatch_d  = miss;
          tgt_ready_d = 1'b1;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      tgt_q       <= '0;
      cur_q       <= '0;
      j_q         <= '0;
      k_q         <= '0;
      e_q         <= 1'b0;
      tgt_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mismatch_q  <= 1'b0;
      cnt_q       <= '0;
`ifdef JK_DRIVER_RETRY_EN
      retry_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      tgt_q       <= tgt_d;
      cur_q       <= cur_d;
      j_q         <= j_d;
      k_q         <= k_d;
      e_q         <= e_d;
      tgt_ready_q <= tgt_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      mismatch_q  <= mismatch_d;
      cnt_q       <= cnt_d;
`ifdef JK_DRIVER_RETRY_EN
      retry_q     <= retry_d;
`endif
    end
  end

  assign bus.tgt_ready = tgt_ready_q;
  assign bus.j         = j_q;
  assign bus.k         = k_q;
  assign bus.e         = e_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.mismatch  = mismatch_q;

endmodule

// File: tb/tb_jk_latch_driver.sv
// Bench for jk_latch_driver: latch-bank environment model plus transaction-level expectations.
module tb_jk_latch_driver;

  localparam int W      = 4;
  localparam int SETTLE = 2;
  localparam int MAXR   = 3;
  localparam int LAT    = SETTLE + 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] bank;
  logic [W-1:0] stuck;
  int           n_tests = 0;
  int           n_fail = 0;
  int           cyc = 0;

  jk_latch_driver_if #(.WIDTH(W)) bus ();

  jk_latch_driver #(
    .WIDTH        (W),
    .SETTLE_CYCLES(SETTLE),
    .MAX_RETRY    (MAXR)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Latch bank as seen by the driver; stuck bits read back as 0.
  assign bus.q_fb = bank & ~stuck;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Runs one target from a negedge; returns at the negedge of the done cycle.
  task automatic run_txn(input logic [W-1:0] tgt, input bit hold,
                         output int done_cyc, output int waited);
    int           attempts;
    int           m;
    int           e_cycles;
    int           busy_bad;
    bit           seen;
    bit           exp_mis;
    logic [W-1:0] jp, kp, exp_j, exp_k;
    exp_mis = |(tgt & stuck);
`ifdef JK_DRIVER_RETRY_EN
    attempts = exp_mis ? MAXR + 1 : 1;
`else
    attempts = 1;
`endif
    bus.tgt_valid = 1'b1;
    bus.tgt_data  = tgt;
    waited = 0;
    while (!bus.tgt_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check_eq("hs_ready", 32'(bus.tgt_ready), 32'd1);
    seen = 1'b0; e_cycles = 0; busy_bad = 0; done_cyc = -1;
    jp = bus.j; kp = bus.k;
    for (m = 0; m < attempts * LAT + 10; m++) begin
      @(negedge clk);
      if (m == 0) begin
        check_eq("ready_low", 32'(bus.tgt_ready), 32'd0);
        if (!hold) bus.tgt_valid = 1'b0;
      end
      if (bus.done) begin
        seen = 1'b1;
        done_cyc = cyc;
        break;
      end
      if (!bus.busy) busy_bad++;
      if (bus.e) begin
        e_cycles++;
        exp_j = tgt & ~bus.q_fb;
        exp_k = bus.q_fb & ~tgt;
        check_eq("drive_j", 32'(bus.j), 32'(exp_j));
        check_eq("drive_k", 32'(bus.k), 32'(exp_k));
        check_eq("jk_excl", 32'(bus.j & bus.k), 32'd0);
        check_eq("jk_setup", 32'({jp, kp}), 32'({bus.j, bus.k}));
        bank = (bank | bus.j) & ~bus.k;
      end
      jp = bus.j; kp = bus.k;
    end
    check_eq("done_seen", 32'(seen), 32'd1);
    check_eq("done_latency", 32'(m), 32'(attempts * LAT));
    check_eq("mismatch", 32'(bus.mismatch), 32'(exp_mis));
    check_eq("e_cycles", 32'(e_cycles), 32'(attempts));
    check_eq("busy_during", 32'(busy_bad), 32'd0);
    check_eq("ready_at_done", 32'(bus.tgt_ready), 32'd1);
    check_eq("qfb_final", 32'(bus.q_fb), 32'(tgt & ~stuck));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d1, d2, w1, w2, dones;
    logic [W-1:0] t;
    bus.tgt_valid = 1'b1;
    bus.tgt_data  = '1;
    bank  = 4'b0011;
    stuck = '0;
    rst_n = 1'b0;

    // Reset held with valid asserted
    repeat (2) begin
      @(negedge clk);
      check_eq("rst_ready", 32'(bus.tgt_ready), 32'd1);
      check_eq("rst_e", 32'(bus.e), 32'd0);
      check_eq("rst_jk", 32'({bus.j, bus.k}), 32'd0);
      check_eq("rst_done", 32'(bus.done), 32'd0);
      check_eq("rst_busy", 32'(bus.busy), 32'd0);
    end
    bus.tgt_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("no_hs_after_rst", 32'(bus.busy), 32'd0);

    // Basic set/reset
    bank = 4'b0011;
    run_txn(4'b0101, 1'b0, d1, w1);
    check_eq("basic_qfb", 32'(bus.q_fb), 32'h5);

    // No-change target
    @(negedge clk);
    bank = 4'b1010;
    run_txn(4'b1010, 1'b0, d1, w1);

    // Stuck-at-0 bit0
    @(negedge clk);
    bank = 4'b0000;
    stuck = 4'b0001;
    run_txn(4'b0001, 1'b0, d1, w1);
    stuck = '0;

    // Back-to-back with valid held
    @(negedge clk);
    bank = 4'b0101;
    run_txn(4'b1111, 1'b1, d1, w1);
    run_txn(4'b0000, 1'b0, d2, w2);
    check_eq("b2b_wait", 32'(w2), 32'd0);
    check_eq("b2b_gap", 32'(d2 - d1), 32'(SETTLE + 4));

    // Reset during SETTLE
    @(negedge clk);
    bank = 4'b0000;
    bus.tgt_valid = 1'b1;
    bus.tgt_data  = 4'b1100;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.tgt_valid = 1'b0;
      if (bus.e) bank = (bank | bus.j) & ~bus.k;
    end
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("mrst_e", 32'(bus.e), 32'd0);
    check_eq("mrst_ready", 32'(bus.tgt_ready), 32'd1);
    check_eq("mrst_busy", 32'(bus.busy), 32'd0);
    check_eq("mrst_done", 32'(bus.done), 32'd0);
    rst_n = 1'b1;
    dones = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    check_eq("mrst_no_done", 32'(dones), 32'd0);
    run_txn(4'b0110, 1'b0, d1, w1);

    // Randomized targets, bank states and occasional stuck bits
    for (int it = 0; it < 24; it++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      bank  = W'($urandom);
      stuck = ($urandom_range(0, 3) == 0) ? W'(1 << $urandom_range(0, W - 1)) : '0;
      t     = W'($urandom);
      run_txn(t, 1'b0, d1, w1);
    end
    stuck = '0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
